// File: rtl/ctl_decode_stage.sv
// RV32I control decoder registered at the ID/EX boundary, with load-use interlock and illegal flagging.
// Latency: one cycle from accept (in_valid & in_ready) to out_valid.
// Backpressure: output register holds while out_valid & !out_ready; in_ready drops on stall or load-use hazard.
module ctl_decode_stage #(
    parameter int XLEN      = 32,
    parameter int ALU_SEL_W = 4,
    parameter int HAZARD_EN = 1,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [XLEN-1:0]      in_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_pc,
    output logic                 a_sel,
    output logic                 b_sel,
    output logic [ALU_SEL_W-1:0] alu_sel,
    output logic [2:0]           imm_sel,
    output logic                 mem_wr,
    output logic                 mem_rd,
    output logic                 reg_wen,
    output logic [1:0]           wb_sel,
    output logic                 pc_sel,
    output logic                 is_branch,
    output logic                 br_un,
    output logic                 illegal,
    output logic [4:0]           rd,
    output logic [4:0]           rs1,
    output logic [4:0]           rs2,
    output logic [2:0]           funct3,
    output logic [CNT_W-1:0]     bubble_cnt
);

    // Opcodes (instr[6:0])
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // funct7 values that carry meaning
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // ALU op encodings
    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0011;
    localparam logic [3:0] ALU_SLL   = 4'b0100;
    localparam logic [3:0] ALU_SRL   = 4'b0101;
    localparam logic [3:0] ALU_SRA   = 4'b0110;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_SLTU  = 4'b1000;
    localparam logic [3:0] ALU_PASSB = 4'b1001;
    localparam logic [3:0] ALU_XOR   = 4'b1010;

    // Immediate formats
    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_B    = 3'd3;
    localparam logic [2:0] IMM_U    = 3'd4;
    localparam logic [2:0] IMM_J    = 3'd5;

    // Writeback sources
    localparam logic [1:0] WB_MEM = 2'b00;
    localparam logic [1:0] WB_ALU = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    typedef struct packed {
        logic                 a_sel;
        logic                 b_sel;
        logic [ALU_SEL_W-1:0] alu_sel;
        logic [2:0]           imm_sel;
        logic                 mem_wr;
        logic                 mem_rd;
        logic                 reg_wen;
        logic [1:0]           wb_sel;
        logic                 pc_sel;
        logic                 is_branch;
        logic                 br_un;
        logic                 illegal;
    } ctl_t;

    // Instruction fields of the incoming word
    logic [6:0] in_opc;
    logic [2:0] in_f3;
    logic [6:0] in_f7;
    logic [4:0] in_rd;
    logic [4:0] in_rs1;
    logic [4:0] in_rs2;

    assign in_opc = in_instr[6:0];
    assign in_rd  = in_instr[11:7];
    assign in_f3  = in_instr[14:12];
    assign in_rs1 = in_instr[19:15];
    assign in_rs2 = in_instr[24:20];
    assign in_f7  = in_instr[31:25];

    ctl_t dec;
    ctl_t ctl_q;
    logic legal;

    // Decode the incoming instruction into the control bundle
    always_comb begin
        dec   = '0;
        legal = 1'b1;
        case (in_opc)
            OPC_LUI: begin
                dec.b_sel   = 1'b1;
                dec.alu_sel = ALU_SEL_W'(ALU_PASSB);
                dec.imm_sel = IMM_U;
                dec.reg_wen = 1'b1;
                dec.wb_sel  = WB_ALU;
            end
            OPC_AUIPC: begin
                dec.a_sel   = 1'b1;
                dec.b_sel   = 1'b1;
                dec.alu_sel = ALU_SEL_W'(ALU_ADD);
                dec.imm_sel = IMM_U;
                dec.reg_wen = 1'b1;
                dec.wb_sel  = WB_ALU;
            end
            OPC_JAL: begin
                dec.a_sel   = 1'b1;
                dec.b_sel   = 1'b1;
                dec.alu_sel = ALU_SEL_W'(ALU_ADD);
                dec.imm_sel = IMM_J;
                dec.reg_wen = 1'b1;
                dec.pc_sel  = 1'b1;
                dec.wb_sel  = WB_PC4;
            end
            OPC_JALR: begin
                dec.b_sel   = 1'b1;
                dec.alu_sel = ALU_SEL_W'(ALU_ADD);
                dec.imm_sel = IMM_I;
                dec.reg_wen = 1'b1;
                dec.pc_sel  = 1'b1;
                dec.wb_sel  = WB_PC4;
                if (in_f3 != 3'b000) legal = 1'b0;
            end
            OPC_BRANCH: begin
                // ALU computes the target; the comparison itself happens in EX
                dec.a_sel     = 1'b1;
                dec.b_sel     = 1'b1;
                dec.alu_sel   = ALU_SEL_W'(ALU_ADD);
                dec.imm_sel   = IMM_B;
                dec.is_branch = 1'b1;
                dec.br_un     = in_f3[1];
                if (in_f3 == 3'b010 || in_f3 == 3'b011) legal = 1'b0;
            end
            OPC_LOAD: begin
                dec.b_sel   = 1'b1;
                dec.alu_sel = ALU_SEL_W'(ALU_ADD);
                dec.imm_sel = IMM_I;
                dec.mem_rd  = 1'b1;
                dec.reg_wen = 1'b1;
                dec.wb_sel  = WB_MEM;
                if (in_f3 == 3'b011 || in_f3 == 3'b110 || in_f3 == 3'b111) legal = 1'b0;
            end
            OPC_STORE: begin
                dec.b_sel   = 1'b1;
                dec.alu_sel = ALU_SEL_W'(ALU_ADD);
                dec.imm_sel = IMM_S;
                dec.mem_wr  = 1'b1;
                if (in_f3 > 3'b010) legal = 1'b0;
            end
            OPC_OPIMM: begin
                dec.b_sel   = 1'b1;
                dec.imm_sel = IMM_I;
                dec.reg_wen = 1'b1;
                dec.wb_sel  = WB_ALU;
                case (in_f3)
                    3'b000: dec.alu_sel = ALU_SEL_W'(ALU_ADD);
                    3'b001: begin
                        dec.alu_sel = ALU_SEL_W'(ALU_SLL);
                        if (in_f7 != F7_BASE) legal = 1'b0;
                    end
                    3'b010: dec.alu_sel = ALU_SEL_W'(ALU_SLT);
                    3'b011: dec.alu_sel = ALU_SEL_W'(ALU_SLTU);
                    3'b100: dec.alu_sel = ALU_SEL_W'(ALU_XOR);
                    3'b101: begin
                        if (in_f7 == F7_BASE)     dec.alu_sel = ALU_SEL_W'(ALU_SRL);
                        else if (in_f7 == F7_ALT) dec.alu_sel = ALU_SEL_W'(ALU_SRA);
                        else                      legal = 1'b0;
                    end
                    3'b110: dec.alu_sel = ALU_SEL_W'(ALU_OR);
                    default: dec.alu_sel = ALU_SEL_W'(ALU_AND);
                endcase
            end
            OPC_OP: begin
                dec.reg_wen = 1'b1;
                dec.wb_sel  = WB_ALU;
                if (in_f7 == F7_BASE) begin
                    case (in_f3)
                        3'b000: dec.alu_sel = ALU_SEL_W'(ALU_ADD);
                        3'b001: dec.alu_sel = ALU_SEL_W'(ALU_SLL);
                        3'b010: dec.alu_sel = ALU_SEL_W'(ALU_SLT);
                        3'b011: dec.alu_sel = ALU_SEL_W'(ALU_SLTU);
                        3'b100: dec.alu_sel = ALU_SEL_W'(ALU_XOR);
                        3'b101: dec.alu_sel = ALU_SEL_W'(ALU_SRL);
                        3'b110: dec.alu_sel = ALU_SEL_W'(ALU_OR);
                        default: dec.alu_sel = ALU_SEL_W'(ALU_AND);
                    endcase
                end else if (in_f7 == F7_ALT) begin
                    if (in_f3 == 3'b000)      dec.alu_sel = ALU_SEL_W'(ALU_SUB);
                    else if (in_f3 == 3'b101) dec.alu_sel = ALU_SEL_W'(ALU_SRA);
                    else                      legal = 1'b0;
                end else begin
                    legal = 1'b0;
                end
            end
            OPC_FENCE, OPC_SYSTEM: begin
                // Architectural no-ops for this pipeline
            end
            default: legal = 1'b0;
        endcase
        // An undecodable word must not disturb machine state, so drop every control
        if (!legal) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

    // Source usage by format: U/J have no rs1, only R/S/B read rs2
    logic rs1_used;
    logic rs2_used;
    assign rs1_used = !(in_opc == OPC_LUI || in_opc == OPC_AUIPC || in_opc == OPC_JAL);
    assign rs2_used = (in_opc == OPC_OP) || (in_opc == OPC_STORE) || (in_opc == OPC_BRANCH);

    logic [4:0] rd_q;
    logic [4:0] rs1_q;
    logic [4:0] rs2_q;
    logic [2:0] f3_q;
    logic [XLEN-1:0] pc_q;
    logic vld_q;

    logic adv;
    logic haz_raw;
    logic haz;
    logic accept;

    assign adv     = !vld_q || out_ready;
    assign haz_raw = in_valid && vld_q && ctl_q.mem_rd && (rd_q != 5'd0) &&
                     ((rs1_used && (rd_q == in_rs1)) || (rs2_used && (rd_q == in_rs2)));
    // Without the interlock the execute stage is expected to forward load data
    assign haz     = (HAZARD_EN != 0) && haz_raw;
    // During flush the wrong-path word is swallowed so upstream can move on
    assign in_ready = flush || (adv && !haz);
    assign accept   = in_valid && in_ready && !flush;

    // Output register: flush empties, otherwise advance loads the decoded bundle or a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            ctl_q <= '0;
            rd_q  <= '0;
            rs1_q <= '0;
            rs2_q <= '0;
            f3_q  <= '0;
            pc_q  <= '0;
        end else if (flush) begin
            vld_q <= 1'b0;
        end else if (adv) begin
            vld_q <= accept;
            if (accept) begin
                ctl_q <= dec;
                rd_q  <= in_rd;
                rs1_q <= in_rs1;
                rs2_q <= in_rs2;
                f3_q  <= in_f3;
                pc_q  <= in_pc;
            end
        end
    end

    // Count inserted load-use bubbles, saturating; flushed cycles are not bubbles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt <= '0;
        end else if (!flush && haz && adv && (bubble_cnt != {CNT_W{1'b1}})) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

    assign out_valid = vld_q;
    assign out_pc    = pc_q;
    assign a_sel     = ctl_q.a_sel;
    assign b_sel     = ctl_q.b_sel;
    assign alu_sel   = ctl_q.alu_sel;
    assign imm_sel   = ctl_q.imm_sel;
    assign mem_wr    = ctl_q.mem_wr;
    assign mem_rd    = ctl_q.mem_rd;
    assign reg_wen   = ctl_q.reg_wen;
    assign wb_sel    = ctl_q.wb_sel;
    assign pc_sel    = ctl_q.pc_sel;
    assign is_branch = ctl_q.is_branch;
    assign br_un     = ctl_q.br_un;
    assign illegal   = ctl_q.illegal;
    assign rd        = rd_q;
    assign rs1       = rs1_q;
    assign rs2       = rs2_q;
    assign funct3    = f3_q;

endmodule

// File: tb/tb_ctl_decode_stage.sv
// Directed bench for ctl_decode_stage: decode, throughput, interlock, stall, flush, illegal, reset.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
// Every check is an immediate assertion that counts failures.
module tb_ctl_decode_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic        a_sel, b_sel, mem_wr, mem_rd, reg_wen, pc_sel, is_branch, br_un, illegal;
    logic [3:0]  alu_sel;
    logic [2:0]  imm_sel;
    logic [1:0]  wb_sel;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [15:0] bubble_cnt;

    ctl_decode_stage #(.XLEN(32), .ALU_SEL_W(4), .HAZARD_EN(1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .a_sel(a_sel), .b_sel(b_sel), .alu_sel(alu_sel), .imm_sel(imm_sel),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .reg_wen(reg_wen), .wb_sel(wb_sel),
        .pc_sel(pc_sel), .is_branch(is_branch), .br_un(br_un), .illegal(illegal),
        .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .bubble_cnt(bubble_cnt)
    );

    localparam logic [31:0] I_LUI1   = 32'h123450B7; // lui x1
    localparam logic [31:0] I_ADD    = 32'h002081B3; // add x3,x1,x2
    localparam logic [31:0] I_SUB    = 32'h40208033; // sub x0,x1,x2
    localparam logic [31:0] I_BLTU   = 32'h0020E063; // bltu x1,x2,0
    localparam logic [31:0] I_SW     = 32'h0020A023; // sw x2,0(x1)
    localparam logic [31:0] I_JALR   = 32'h000100E7; // jalr x1,0(x2)
    localparam logic [31:0] I_LW5    = 32'h0000A283; // lw x5,0(x1)
    localparam logic [31:0] I_USE5   = 32'h00128333; // add x6,x5,x1
    localparam logic [31:0] I_LW0    = 32'h0000A003; // lw x0,0(x1)
    localparam logic [31:0] I_LUI6   = 32'h00028337; // lui x6 with rs1 field = 5
    localparam logic [31:0] I_SRAI   = 32'h4030D193; // srai x3,x1,3
    localparam logic [31:0] I_BADOPC = 32'h0000007F;
    localparam logic [31:0] I_MUL    = 32'h022081B3; // funct7 0000001
    localparam logic [31:0] I_FENCE  = 32'h0000000F;

    int n_assert = 0;
    int n_fail   = 0;

    logic [17:0] ctl_obs;
    assign ctl_obs = {a_sel, b_sel, alu_sel, imm_sel, mem_wr, mem_rd, reg_wen,
                      wb_sel, pc_sel, is_branch, br_un, illegal};

    function automatic logic [17:0] ctl_exp(input logic a, input logic b, input logic [3:0] alu,
                                            input logic [2:0] imm, input logic wr, input logic ld,
                                            input logic wen, input logic [1:0] wb, input logic pc,
                                            input logic br, input logic un, input logic ill);
        return {a, b, alu, imm, wr, ld, wen, wb, pc, br, un, ill};
    endfunction

    localparam logic [17:0] C_LUI  = {1'b0,1'b1,4'b1001,3'd4,1'b0,1'b0,1'b1,2'b01,1'b0,1'b0,1'b0,1'b0};
    localparam logic [17:0] C_ADD  = {1'b0,1'b0,4'b0010,3'd0,1'b0,1'b0,1'b1,2'b01,1'b0,1'b0,1'b0,1'b0};
    localparam logic [17:0] C_LW   = {1'b0,1'b1,4'b0010,3'd1,1'b0,1'b1,1'b1,2'b00,1'b0,1'b0,1'b0,1'b0};
    localparam logic [17:0] C_ILL  = 18'h00001;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(I_LUI1, 32'h100);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_bubble_cnt", 32'(bubble_cnt), 32'd0);
        chk("rst_ctl", 32'(ctl_obs), 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("lui_valid", 32'(out_valid), 32'd1);
        chk("lui_rd", 32'(rd), 32'd1);
        chk("lui_ctl", 32'(ctl_obs), 32'(C_LUI));
        chk("lui_pc", out_pc, 32'h100);

        // Back-to-back stream
        drive(I_ADD, 32'h104);
        tick();
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_ctl", 32'(ctl_obs), 32'(C_ADD));
        chk("add_regs", 32'({rd, rs1, rs2, funct3}), 32'({5'd3, 5'd1, 5'd2, 3'd0}));
        drive(I_SUB, 32'h108);
        tick();
        chk("sub_valid", 32'(out_valid), 32'd1);
        chk("sub_ctl", 32'(ctl_obs),
            32'(ctl_exp(1'b0,1'b0,4'b0011,3'd0,1'b0,1'b0,1'b1,2'b01,1'b0,1'b0,1'b0,1'b0)));
        drive(I_BLTU, 32'h10C);
        tick();
        chk("bltu_valid", 32'(out_valid), 32'd1);
        chk("bltu_ctl", 32'(ctl_obs),
            32'(ctl_exp(1'b1,1'b1,4'b0010,3'd3,1'b0,1'b0,1'b0,2'b00,1'b0,1'b1,1'b1,1'b0)));
        chk("bltu_funct3", 32'(funct3), 32'd6);
        drive(I_SW, 32'h110);
        tick();
        chk("sw_valid", 32'(out_valid), 32'd1);
        chk("sw_ctl", 32'(ctl_obs),
            32'(ctl_exp(1'b0,1'b1,4'b0010,3'd2,1'b1,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0)));
        drive(I_JALR, 32'h114);
        tick();
        chk("jalr_valid", 32'(out_valid), 32'd1);
        chk("jalr_ctl", 32'(ctl_obs),
            32'(ctl_exp(1'b0,1'b1,4'b0010,3'd1,1'b0,1'b0,1'b1,2'b10,1'b1,1'b0,1'b0,1'b0)));
        chk("jalr_pc", out_pc, 32'h114);
        in_valid = 1'b0;
        tick();
        chk("idle_valid", 32'(out_valid), 32'd0);

        // Load-use: exactly one bubble
        drive(I_LW5, 32'h200);
        tick();
        chk("lw5_ctl", 32'(ctl_obs), 32'(C_LW));
        drive(I_USE5, 32'h204);
        #1;
        chk("haz_in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("bubble_valid", 32'(out_valid), 32'd0);
        chk("bubble_cnt1", 32'(bubble_cnt), 32'd1);
        chk("bubble_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("use_valid", 32'(out_valid), 32'd1);
        chk("use_pc", out_pc, 32'h204);
        chk("use_rd", 32'(rd), 32'd6);

        // Load to x0 never interlocks
        drive(I_LW0, 32'h208);
        tick();
        drive(I_USE5, 32'h20C);
        #1;
        chk("lw0_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("lw0_use_pc", out_pc, 32'h20C);
        chk("lw0_cnt", 32'(bubble_cnt), 32'd1);

        // U-type does not read rs1 even if the field matches
        drive(I_LW5, 32'h210);
        tick();
        drive(I_LUI6, 32'h214);
        #1;
        chk("lui6_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("lui6_pc", out_pc, 32'h214);
        chk("lui6_ctl", 32'(ctl_obs), 32'(C_LUI));
        chk("lui6_cnt", 32'(bubble_cnt), 32'd1);

        // Backpressure: hold LUI x6 for 3 cycles
        drive(I_ADD, 32'h300);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            tick();
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_pc", out_pc, 32'h214);
            chk("bp_ctl", 32'(ctl_obs), 32'(C_LUI));
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        chk("bp_add_pc", out_pc, 32'h300);
        chk("bp_add_ctl", 32'(ctl_obs), 32'(C_ADD));
        drive(I_SUB, 32'h304);
        tick();
        chk("bp_next_pc", out_pc, 32'h304);

        // Flush with a held bundle and a valid incoming word
        drive(I_ADD, 32'h400);
        tick();
        chk("fl_pre_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b0;
        flush = 1'b1;
        drive(I_SW, 32'h404);
        #1;
        chk("fl_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("fl_valid", 32'(out_valid), 32'd0);
        flush = 1'b0;
        out_ready = 1'b1;
        drive(I_BLTU, 32'h408);
        tick();
        chk("fl_after_pc", out_pc, 32'h408);
        chk("fl_after_valid", 32'(out_valid), 32'd1);

        // Flush during a load-use hazard: no bubble counted
        drive(I_LW5, 32'h500);
        tick();
        drive(I_USE5, 32'h504);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flhaz_valid", 32'(out_valid), 32'd0);
        chk("flhaz_cnt", 32'(bubble_cnt), 32'd1);

        // Illegal and no-op decodes
        drive(I_BADOPC, 32'h600);
        tick();
        chk("badopc_ctl", 32'(ctl_obs), 32'(C_ILL));
        drive(I_MUL, 32'h604);
        tick();
        chk("mul_ctl", 32'(ctl_obs), 32'(C_ILL));
        chk("mul_reg_wen", 32'(reg_wen), 32'd0);
        drive(I_FENCE, 32'h608);
        tick();
        chk("fence_valid", 32'(out_valid), 32'd1);
        chk("fence_ctl", 32'(ctl_obs), 32'd0);
        drive(I_SRAI, 32'h60C);
        tick();
        chk("srai_ctl", 32'(ctl_obs),
            32'(ctl_exp(1'b0,1'b1,4'b0110,3'd1,1'b0,1'b0,1'b1,2'b01,1'b0,1'b0,1'b0,1'b0)));

        // Asynchronous reset while stalled
        drive(I_ADD, 32'h700);
        tick();
        out_ready = 1'b0;
        drive(I_SUB, 32'h704);
        #1;
        chk("ar_stall_ready", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_cnt", 32'(bubble_cnt), 32'd0);
        chk("ar_ctl", 32'(ctl_obs), 32'd0);
        #1;
        rst_n = 1'b1;
        #1;
        chk("ar_in_ready", 32'(in_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
